// File: rtl/push_button_ctrl.sv
// Multi-channel push-button front end: synchronise, debounce, then map presses
// to latch / toggle / pulse / auto-repeat outputs selected per channel at runtime.
module push_button_ctrl #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 256,
  parameter int REPEAT_PERIOD   = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_BTN-1:0]     i_push_button,
  input  logic [2*N_BTN-1:0]   i_mode,
  input  logic [N_BTN-1:0]     i_clear,
  output logic [N_BTN-1:0]     o_signal,
  output logic [N_BTN-1:0]     o_pressed,
  output logic                 o_any
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] MODE_LATCH  = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    REP_IDLE       = 2'd0,
    REP_WAIT_FIRST = 2'd1,
    REP_REPEATING  = 2'd2
  } rep_state_t;

  // Output semantics: in pulse/repeat modes o_signal is a one-cycle strobe that the
  // consumer must take on the cycle it is high (no back-pressure); in latch/toggle
  // modes it is a level held until i_clear or the next press.

  for (genvar c = 0; c < N_BTN; c++) begin : g_ch
    logic             sync0, sync1, p;
    logic             db, db_q, press_evt;
    logic [DB_W-1:0]  cnt;
    logic [1:0]       mode;
    logic             sig, sig_nxt, rep_fire;
    rep_state_t       state, state_nxt;
    logic [REP_W-1:0] rcnt, rcnt_nxt;

    assign mode      = i_mode[2*c +: 2];
    assign p         = ~sync1;
    assign press_evt = db & ~db_q;
    assign o_pressed[c] = db;
    assign o_signal[c]  = sig;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        sync0 <= 1'b1;
        sync1 <= 1'b1;
        db    <= 1'b0;
        db_q  <= 1'b0;
        cnt   <= '0;
        sig   <= 1'b0;
        state <= REP_IDLE;
        rcnt  <= '0;
      end else begin
        sync0 <= i_push_button[c];
        sync1 <= sync0;
        // Any sample agreeing with the accepted level restarts the stability count.
        if (p == db) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          db  <= p;
          cnt <= '0;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
        db_q  <= db;
        sig   <= sig_nxt;
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      rep_fire  = 1'b0;
      if (!db || mode != MODE_REPEAT) begin
        state_nxt = REP_IDLE;
        rcnt_nxt  = '0;
      end else begin
        case (state)
          REP_IDLE: begin
            if (press_evt) begin
              state_nxt = REP_WAIT_FIRST;
              rcnt_nxt  = '0;
            end
          end
          REP_WAIT_FIRST: begin
            if (rcnt == DELAY_LAST) begin
              rep_fire  = 1'b1;
              state_nxt = REP_REPEATING;
              rcnt_nxt  = '0;
            end else begin
              rcnt_nxt = rcnt + REP_W'(1);
            end
          end
          REP_REPEATING: begin
            if (rcnt == PERIOD_LAST) begin
              rep_fire = 1'b1;
              rcnt_nxt = '0;
            end else begin
              rcnt_nxt = rcnt + REP_W'(1);
            end
          end
          default: state_nxt = REP_IDLE;
        endcase
      end

      sig_nxt = sig;
      case (mode)
        MODE_LATCH: begin
          if (press_evt)    sig_nxt = 1'b1;
          else if (i_clear[c]) sig_nxt = 1'b0;
        end
        MODE_TOGGLE: begin
          if (press_evt)    sig_nxt = ~sig;
          else if (i_clear[c]) sig_nxt = 1'b0;
        end
        MODE_PULSE: sig_nxt = press_evt;
        default:    sig_nxt = press_evt | rep_fire;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) o_any <= 1'b0;
    else         o_any <= |o_pressed;
  end

endmodule

// File: tb/tb_push_button_ctrl.sv
// Directed bench for push_button_ctrl: stimulus pushes timed expected output
// vectors into a queue; a monitor pops one on every output change and compares.
module tb_push_button_ctrl;

  localparam int W = 33;  // {cycle[23:0], o_signal[3:0], o_pressed[3:0], o_any}

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_push_button;
  logic [7:0] i_mode;
  logic [3:0] i_clear;
  logic [3:0] o_signal;
  logic [3:0] o_pressed;
  logic       o_any;

  push_button_ctrl #(
    .N_BTN(4), .DEBOUNCE_CYCLES(16), .REPEAT_DELAY(256), .REPEAT_PERIOD(64)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_push_button(i_push_button),
    .i_mode(i_mode),
    .i_clear(i_clear),
    .o_signal(o_signal),
    .o_pressed(o_pressed),
    .o_any(o_any)
  );

  // clock / cycle counter
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic       mon_en = 1'b0;
  logic [8:0] prev   = 9'b0;

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic exp_ev(input int c, input logic [3:0] s, input logic [3:0] p, input logic a);
    logic [23:0] cc;
    cc = c[23:0];
    exp_q.push_back({cc, s, p, a});
  endtask

  // monitor
  always @(negedge i_clk) begin
    logic [8:0]   cur;
    logic [W-1:0] e, got;
    if (mon_en) begin
      cur = {o_signal, o_pressed, o_any};
      if (cur !== prev) begin
        checks++;
        got = {cyc[23:0], cur};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d sig=%b prs=%b any=%b required=no change",
                   cyc, cur[8:5], cur[4:1], cur[0]);
        end else begin
          e = exp_q.pop_front();
          if (e !== got) begin
            failures++;
            $display("FAIL output_event got cyc=%0d sig=%b prs=%b any=%b required cyc=%0d sig=%b prs=%b any=%b",
                     got[32:9], got[8:5], got[4:1], got[0], e[32:9], e[8:5], e[4:1], e[0]);
          end
        end
        prev = cur;
      end
    end
  end

  // stimulus
  initial begin
    int r, a, c, k, t0, m;
    i_reset       = 1'b1;
    i_push_button = 4'b0000;
    i_mode        = 8'h00;
    i_clear       = 4'b0000;
    step(3);
    checks++;
    if ({o_signal, o_pressed, o_any} !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got=%b required=000000000", {o_signal, o_pressed, o_any});
    end
    mon_en  = 1'b1;

    // reset release with all pins held pressed, all latch mode
    i_reset = 1'b0;
    r = cyc;
    exp_ev(r + 18, 4'b0000, 4'b1111, 1'b0);
    exp_ev(r + 19, 4'b1111, 4'b1111, 1'b1);
    step(25);
    i_push_button = 4'b1111;
    a = cyc;
    exp_ev(a + 18, 4'b1111, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b1111, 4'b0000, 1'b0);
    step(25);
    i_clear = 4'b1111;
    c = cyc;
    exp_ev(c + 1, 4'b0000, 4'b0000, 1'b0);
    step(1);
    i_clear = 4'b0000;

    // bounce on channel 0: toggles every 5 cycles for 100 cycles, then stays low
    step(10);
    for (int i = 0; i < 20; i++) begin
      i_push_button[0] = i[0];
      step(5);
    end
    i_push_button[0] = 1'b0;
    k = cyc;
    exp_ev(k + 18, 4'b0000, 4'b0001, 1'b0);
    exp_ev(k + 19, 4'b0001, 4'b0001, 1'b1);
    step(30);
    i_push_button[0] = 1'b1;
    a = cyc;
    exp_ev(a + 18, 4'b0001, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0001, 4'b0000, 1'b0);
    step(25);
    i_clear[0] = 1'b1;
    c = cyc;
    exp_ev(c + 1, 4'b0000, 4'b0000, 1'b0);
    step(1);
    i_clear[0] = 1'b0;

    // latch: clear coinciding with the press event loses to the press
    step(5);
    i_push_button[0] = 1'b0;
    k = cyc;
    exp_ev(k + 18, 4'b0000, 4'b0001, 1'b0);
    exp_ev(k + 19, 4'b0001, 4'b0001, 1'b1);
    step(18);
    i_clear[0] = 1'b1;
    step(1);
    i_clear[0] = 1'b0;
    step(20);
    i_push_button[0] = 1'b1;
    a = cyc;
    exp_ev(a + 18, 4'b0001, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0001, 4'b0000, 1'b0);
    step(25);
    i_clear[0] = 1'b1;
    c = cyc;
    exp_ev(c + 1, 4'b0000, 4'b0000, 1'b0);
    step(1);
    i_clear[0] = 1'b0;

    // toggle on channel 1: two presses -> 1 then 0
    i_mode[3:2] = 2'b01;
    step(5);
    i_push_button[1] = 1'b0;
    k = cyc;
    exp_ev(k + 18, 4'b0000, 4'b0010, 1'b0);
    exp_ev(k + 19, 4'b0010, 4'b0010, 1'b1);
    step(30);
    i_push_button[1] = 1'b1;
    a = cyc;
    exp_ev(a + 18, 4'b0010, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0010, 4'b0000, 1'b0);
    step(30);
    i_push_button[1] = 1'b0;
    k = cyc;
    exp_ev(k + 18, 4'b0010, 4'b0010, 1'b0);
    exp_ev(k + 19, 4'b0000, 4'b0010, 1'b1);
    step(30);
    i_push_button[1] = 1'b1;
    a = cyc;
    exp_ev(a + 18, 4'b0000, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0000, 4'b0000, 1'b0);

    // pulse on channel 2: held 1000 cycles, clear ignored
    i_mode[5:4] = 2'b10;
    step(30);
    i_push_button[2] = 1'b0;
    k = cyc;
    exp_ev(k + 18, 4'b0000, 4'b0100, 1'b0);
    exp_ev(k + 19, 4'b0100, 4'b0100, 1'b1);
    exp_ev(k + 20, 4'b0000, 4'b0100, 1'b1);
    step(500);
    i_clear[2] = 1'b1;
    step(3);
    i_clear[2] = 1'b0;
    step(497);
    i_push_button[2] = 1'b1;
    a = cyc;
    exp_ev(a + 18, 4'b0000, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0000, 4'b0000, 1'b0);

    // repeat on channel 3: held 500 cycles, clear ignored
    i_mode[7:6] = 2'b11;
    step(30);
    i_push_button[3] = 1'b0;
    k  = cyc;
    t0 = k + 19;
    exp_ev(k + 18, 4'b0000, 4'b1000, 1'b0);
    exp_ev(t0,     4'b1000, 4'b1000, 1'b1);
    exp_ev(t0 + 1, 4'b0000, 4'b1000, 1'b1);
    for (int d = 256; d <= 448; d += 64) begin
      exp_ev(t0 + d,     4'b1000, 4'b1000, 1'b1);
      exp_ev(t0 + d + 1, 4'b0000, 4'b1000, 1'b1);
    end
    step(100);
    i_clear[3] = 1'b1;
    step(50);
    i_clear[3] = 1'b0;
    step(350);
    i_push_button[3] = 1'b1;
    a = cyc;
    exp_ev(a + 18, 4'b0000, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0000, 4'b0000, 1'b0);

    // re-press restarts with the full delay
    step(100);
    i_push_button[3] = 1'b0;
    k  = cyc;
    t0 = k + 19;
    exp_ev(k + 18,   4'b0000, 4'b1000, 1'b0);
    exp_ev(t0,       4'b1000, 4'b1000, 1'b1);
    exp_ev(t0 + 1,   4'b0000, 4'b1000, 1'b1);
    exp_ev(t0 + 256, 4'b1000, 4'b1000, 1'b1);
    exp_ev(t0 + 257, 4'b0000, 4'b1000, 1'b1);
    step(300);
    i_push_button[3] = 1'b1;
    a = cyc;
    exp_ev(a + 18, 4'b0000, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0000, 4'b0000, 1'b0);

    // all channels, modes 00/01/10/11, pressed together; then a mid-press reset
    i_mode = 8'b11_10_01_00;
    step(30);
    i_push_button = 4'b0000;
    k = cyc;
    exp_ev(k + 18, 4'b0000, 4'b1111, 1'b0);
    exp_ev(k + 19, 4'b1111, 4'b1111, 1'b1);
    exp_ev(k + 20, 4'b0011, 4'b1111, 1'b1);
    step(30);
    i_reset = 1'b1;
    exp_ev(cyc + 1, 4'b0000, 4'b0000, 1'b0);
    step(1);
    i_reset = 1'b0;
    r = cyc;
    exp_ev(r + 18, 4'b0000, 4'b1111, 1'b0);
    exp_ev(r + 19, 4'b1111, 4'b1111, 1'b1);
    exp_ev(r + 20, 4'b0011, 4'b1111, 1'b1);
    step(29);
    i_push_button = 4'b1111;
    a = cyc;
    exp_ev(a + 18, 4'b0011, 4'b0000, 1'b1);
    exp_ev(a + 19, 4'b0011, 4'b0000, 1'b0);

    // mode switches: latch<->toggle holds the value, into pulse forces 0
    step(25);
    i_mode[1:0] = 2'b01;
    step(5);
    i_mode[1:0] = 2'b00;
    step(5);
    i_mode[3:2] = 2'b10;
    m = cyc;
    exp_ev(m + 1, 4'b0001, 4'b0000, 1'b0);
    step(40);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
